// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: hazard-controller FSM states, forwarding select
// encodings and the forwarding match helper.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hcu_state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // The EX/MEM result is younger than MEM/WB, so it wins when both match.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] src,
    input logic [4:0] mem_rd,
    input logic       mem_regwrite,
    input logic [4:0] wb_rd,
    input logic       wb_regwrite
  );
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == src)
      return FWD_EXMEM;
    else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == src)
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational ALU operand forwarding select for the EX stage.
module forward_unit
  import cpu_types_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  assign forward_a = fwd_select(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
  assign forward_b = fwd_select(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard/stall controller: data-cache wait and halt FSM, Mealy
// priority control of register enables and flushes, stall/flush counters.
module hazard_control_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_dreq,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             wb_halt,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             stall,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles,
  output hcu_state_t       dbg_state
);

  hcu_state_t state_q, state_d;
  logic       load_use, halt_cond, data_wait;

  // Cache handshake: ihit/dhit are single-cycle completion strobes; a request
  // (fetch always, data when mem_dreq) is held until the cycle its hit is seen.
  assign load_use  = ex_memtoreg && ex_regwrite && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs1 && id_uses_rs1) ||
                      (ex_rd == id_rs2 && id_uses_rs2));
  assign halt_cond = (state_q == HALT) || wb_halt;
  // The dhit that ends a DWAIT is itself a normal (advancing) cycle.
  assign data_wait = !dhit && ((state_q == DWAIT) || (state_q == RUN && mem_dreq));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    stall        = 1'b0;
    halted       = 1'b0;
    if (halt_cond) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = 5'b0;
      halted = 1'b1;
    end else if (data_wait) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = 5'b0;
      stall = 1'b1;
    end else if (ex_redirect) begin
      // Wrong-path ID instruction: any load-use match against it is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use || !ihit) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      stall       = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (wb_halt)
          state_d = HALT;
        else if (mem_dreq && !dhit)
          state_d = DWAIT;
      end
      DWAIT: begin
        if (dhit)
          state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= RUN;
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      state_q <= state_d;
      if (stall && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + 1'b1;
      if ((if_id_flush || id_ex_flush) && flush_cycles != {CNT_W{1'b1}})
        flush_cycles <= flush_cycles + 1'b1;
    end
  end

  assign dbg_state = state_q;

  forward_unit u_forward_unit (
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .forward_a    (forwardA),
    .forward_b    (forwardB)
  );

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard and stall controller for the five-stage RISC pipeline. Consumes register-address and control fields from the IF/ID, ID/EX, EX/MEM and MEM/WB registers plus cache handshakes (`ihit`, `dhit`), and drives the hazard and forwarding controls: per-stage write enables, flushes, `stall`, `pc_write` and `forwardA/B`. A small FSM tracks data-cache waits and the terminal halt. Saturating counters record stall and flush cycles for performance checks.

## Interface
- `CNT_W`, 32, width of the performance counters.

Ports:
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `ihit` in 1: instruction fetch complete this cycle.
- `dhit` in 1: data access complete this cycle.
- `id_rs1`, `id_rs2` in 5: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1: the ID instruction reads that source.
- `ex_rs1`, `ex_rs2` in 5: source registers held in ID/EX.
- `ex_rd` in 5, `ex_regwrite` in 1, `ex_memtoreg` in 1: ID/EX destination and controls.
- `ex_redirect` in 1: EX resolved a taken branch or jump (PC target valid).
- `mem_rd` in 5, `mem_regwrite` in 1: EX/MEM destination.
- `mem_dreq` in 1: EX/MEM instruction issues a load or store.
- `wb_rd` in 5, `wb_regwrite` in 1: MEM/WB destination.
- `wb_halt` in 1: MEM/WB holds a halt.
- `pc_write` out 1, `if_id_write` out 1, `id_ex_write` out 1, `ex_mem_write` out 1, `mem_wb_write` out 1: register enables.
- `if_id_flush` out 1, `id_ex_flush` out 1: load a bubble on the next edge.
- `stall` out 1: pipeline not advancing normally.
- `forwardA`, `forwardB` out 2: ALU operand source select.
- `halted` out 1: sticky halt.
- `stall_cycles`, `flush_cycles` out CNT_W: saturating counters.

## Operation
- FSM states: RUN, DWAIT, HALT. Reset state is RUN.
- **RUN to HALT:** `wb_halt` moves the FSM to HALT. HALT is exited only by `nRST`.
- **RUN to DWAIT:** `mem_dreq && !dhit` moves the FSM to DWAIT.
- **DWAIT to RUN:** `dhit` returns the FSM to RUN.
- Control priority, highest first. Each item applies only if no higher item applies; enables not named are 1 and flushes not named are 0.
  1. **HALT or `wb_halt`:** all enables 0, all flushes 0, `halted` = 1.
  2. **Data wait** (state DWAIT, or RUN with `mem_dreq && !dhit`): all enables 0, no flush, `stall` = 1.
  3. **`ex_redirect`:** `pc_write` = 1, `if_id_flush` = 1, `id_ex_flush` = 1. This applies even when `ihit` = 0. A concurrent load-use hazard is ignored because the ID instruction is wrong-path.
  4. **Load-use hazard:** `ex_memtoreg && ex_regwrite && ex_rd != 0` and (`ex_rd == id_rs1 && id_uses_rs1` or `ex_rd == id_rs2 && id_uses_rs2`). Outputs: `pc_write` = 0, `if_id_write` = 0, `id_ex_flush` = 1, `stall` = 1.
  5. **`!ihit`:** `pc_write` = 0, `if_id_write` = 0, `id_ex_flush` = 1, `stall` = 1.
- A redirect raised while in DWAIT stays asserted because EX is frozen. It is serviced in the cycle `dhit` releases the wait.
- Forwarding is combinational and is evaluated independently of stall state.
  - `forwardA` = 01 if `mem_regwrite && mem_rd != 0 && mem_rd == ex_rs1`.
  - Otherwise 10 if `wb_regwrite && wb_rd != 0 && wb_rd == ex_rs1`.
  - Otherwise 00.
  - `forwardB` uses the same rules with `ex_rs2`.
  - The EX/MEM match has priority over MEM/WB.
- Counters:
  - `stall_cycles` increments on each edge where `stall` = 1 (HALT excluded).
  - `flush_cycles` increments on each edge where `if_id_flush || id_ex_flush`.
  - Both saturate at all-ones.

## Timing
- Control outputs are Mealy: they are combinational from the state register and the current inputs, with zero-cycle latency. The FSM state and the counters are registered.
- A load-use hazard produces exactly one bubble. The next cycle the load is in MEM and the condition clears with no state needed.
- `dhit` in the same cycle as `mem_dreq`: no stall and no DWAIT entry.
- During asynchronous reset (`nRST` = 0): state is RUN, counters are 0, `halted` = 0. Outputs follow the combinational rules for the current inputs.
- Asserting reset mid-DWAIT or in HALT returns the FSM to RUN immediately, independent of `CLK`.

## Structure
- Shared package `cpu_types_pkg` holds:
  - the FSM state enum `hcu_state_t`;
  - the forwarding encodings `FWD_RF` = 2'b00, `FWD_EXMEM` = 2'b01, `FWD_MEMWB` = 2'b10.
- Sub-module `forward_unit` (combinational) produces `forwardA` and `forwardB`. The FSM, priority logic and counters live in the top module.

## Test plan
- **Load-use hazard:** `ex_memtoreg` = 1, `ex_rd` = 5, `id_rs1` = 5, `ihit` = 1. Required: one cycle with `pc_write` = 0, `if_id_write` = 0, `id_ex_flush` = 1; `stall_cycles` 0 to 1.
- **Data-cache wait:** `mem_dreq` = 1, `dhit` = 0 for 3 cycles, then 1. Required: all enables 0 for 3 cycles, state DWAIT, then RUN with all enables 1; `stall_cycles` = 3.
- **Redirect under load-use:** `ex_redirect` = 1 with a load-use match and `ihit` = 0. Required: `pc_write` = 1, both flushes 1, `if_id_write` = 1; `flush_cycles` +1.
- **Forwarding priority:** `mem_rd` = `wb_rd` = `ex_rs1` = 7, both regwrite = 1. Required: `forwardA` = 01. With `mem_rd` = 0: `forwardA` = 10. With `ex_rs1` = 0: `forwardA` = 00.
- **Halt:** `wb_halt` pulsed for 1 cycle. Required: `halted` = 1 and all enables 0 from then on; `nRST` low then high restores RUN with counters 0.
- **Redirect held through a data wait:** `ex_redirect` asserted during a 2-cycle data wait. Required: no flush during the wait; flushes and `pc_write` = 1 in the `dhit` release cycle.
